// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between instruction fetch (I) and loads (D), one read in flight.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed D-over-I priority.
`timescale 1ns/1ps
module mem_read_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_flush,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_ren,
  input  logic [ADDR_W-1:0] d_raddr,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises x_ren with x_raddr stable and holds both until the
  // single-cycle x_rvalid pulse; the memory answers each one-cycle mem_ren with one mem_rvalid.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic              mem_ren_q, mem_ren_d;
  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
  logic              gnt_i, gnt_d;
  logic              i_hit, d_hit;

`ifdef MEM_ARB_RR_EN
  // lg_q = 0: I was granted last, 1: D was granted last
  logic lg_q, lg_d;

  always_comb begin
    gnt_i = i_ren;
    gnt_d = d_ren;
    if (i_ren && d_ren) begin
      gnt_i = lg_q;
      gnt_d = !lg_q;
    end
  end
`else
  always_comb begin
    gnt_d = d_ren;
    gnt_i = i_ren && !d_ren;
  end
`endif

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    mem_ren_d   = 1'b0;
    mem_raddr_d = '0;
    i_hit       = 1'b0;
    d_hit       = 1'b0;
`ifdef MEM_ARB_RR_EN
    lg_d        = lg_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_i) begin
          state_d     = BUSY_I;
          mem_ren_d   = 1'b1;
          mem_raddr_d = i_raddr;
          drop_d      = i_flush;
`ifdef MEM_ARB_RR_EN
          lg_d        = 1'b0;
`endif
        end else if (gnt_d) begin
          state_d     = BUSY_D;
          mem_ren_d   = 1'b1;
          mem_raddr_d = d_raddr;
`ifdef MEM_ARB_RR_EN
          lg_d        = 1'b1;
`endif
        end
      end
      BUSY_I: begin
        if (i_flush) drop_d = 1'b1;
        // a flush arriving with the response still kills it
        if (mem_rvalid) begin
          i_hit   = !(drop_q || i_flush);
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      BUSY_D: begin
        if (mem_rvalid) begin
          d_hit   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_raddr_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      mem_ren_q   <= mem_ren_d;
      mem_raddr_q <= mem_raddr_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) lg_q <= 1'b0;
    else     lg_q <= lg_d;
  end
`endif

  // Responses are steered combinationally; reset masks anything still arriving.
  assign i_rvalid  = i_hit && !rst;
  assign d_rvalid  = d_hit && !rst;
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign mem_ren   = mem_ren_q;
  assign mem_raddr = mem_raddr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: memory model, per-side expected queues, grant-policy model.
`timescale 1ns/1ps
module tb_mem_read_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 3000;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_ren = 1'b0, d_ren = 1'b0, i_flush = 1'b0;
  logic [AW-1:0] i_raddr = '0, d_raddr = '0;
  logic          i_rvalid, d_rvalid, mem_ren;
  logic [DW-1:0] i_rdata, d_rdata;
  logic [AW-1:0] mem_raddr;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state;

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_raddr(i_raddr), .i_flush(i_flush),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_raddr(d_raddr),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0, n_err = 0;
  logic [DW-1:0] i_exp_q[$], d_exp_q[$];
  int            i_rv_cnt = 0, d_rv_cnt = 0, last_ren_cyc = -1;

  // memory model
  int            mem_lat = 0;
  bit            mem_busy = 1'b0, stray_req = 1'b0, fixed_en = 1'b0;
  int            mem_cnt = 0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] fixed_val = '0;

  // grant reference: who asked in the cycle before each mem_ren, and who was served last
  bit            m_lg = 1'b0;
  bit            p_i_ren = 1'b0, p_d_ren = 1'b0, rst_prev = 1'b0, ren_prev = 1'b0;
  logic [AW-1:0] p_i_addr = '0, p_d_addr = '0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, a[63:32] ^ a[31:0] ^ 32'h0F0F_1234};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    bit r;
    r = rst;
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (r) begin
      mem_busy  = 1'b0;
    end else if (stray_req && !mem_busy) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      stray_req  = 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = fixed_en ? fixed_val : mem_fn(mem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit            exp_side;
    logic [AW-1:0] exp_addr;
    if (rst) begin
      m_lg = 1'b0;
      n_cmp++;
      if (i_rvalid || d_rvalid || i_rdata != '0 || d_rdata != '0 ||
          (rst_prev && (mem_ren || mem_raddr != '0))) begin
        n_err++;
        $display("FAIL reset_outputs: got ren=%b raddr=%h irv=%b drv=%b, required all 0",
                 mem_ren, mem_raddr, i_rvalid, d_rvalid);
      end
    end else begin
      if (i_rvalid) begin
        i_rv_cnt++;
        if (i_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL i_unexpected: got i_rvalid with %h, required no response", i_rdata);
        end else check("i_rdata", i_rdata, i_exp_q.pop_front());
      end
      if (d_rvalid) begin
        d_rv_cnt++;
        if (d_exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL d_unexpected: got d_rvalid with %h, required no response", d_rdata);
        end else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
      if (i_rvalid && d_rvalid) begin
        n_cmp++; n_err++;
        $display("FAIL rvalid_excl: got both rvalid=1, required at most one");
      end
      if (mem_ren) begin
        last_ren_cyc = cyc;
        if (ren_prev) begin
          n_cmp++; n_err++;
          $display("FAIL mem_ren_width: got 2-cycle strobe, required 1");
        end
        if (mem_busy) begin
          n_cmp++; n_err++;
          $display("FAIL outstanding: got second read, required at most one in flight");
        end
        if (!p_i_ren && !p_d_ren) begin
          n_cmp++; n_err++;
          $display("FAIL grant_src: got mem_ren %h, required no read (no requester)", mem_raddr);
        end else begin
          if (p_i_ren && p_d_ren) exp_side = RR ? !m_lg : 1'b1;
          else                    exp_side = p_d_ren;
          exp_addr = exp_side ? p_d_addr : p_i_addr;
          check(exp_side ? "grant_d_addr" : "grant_i_addr", mem_raddr, exp_addr);
          m_lg = exp_side;
        end
        mem_busy = 1'b1;
        mem_addr = mem_raddr;
        mem_cnt  = (mem_lat < 0) ? $urandom_range(0, 3) : mem_lat;
      end
    end
    rst_prev = rst;
    ren_prev = mem_ren;
    p_i_ren  = i_ren;  p_i_addr = i_raddr;
    p_d_ren  = d_ren;  p_d_addr = d_raddr;
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic req(input bit side, input logic [AW-1:0] a, input logic [DW-1:0] e,
                     output int lat);
    if (side) begin d_ren = 1'b1; d_raddr = a; d_exp_q.push_back(e); end
    else      begin i_ren = 1'b1; i_raddr = a; i_exp_q.push_back(e); end
    lat = 0;
    forever begin
      @(negedge clk);
      if (side ? d_rvalid : i_rvalid) break;
      lat++;
      if (lat > TMO) begin
        n_cmp++; n_err++;
        $display("FAIL %s_timeout: got no rvalid in %0d cycles, required a response",
                 side ? "d" : "i", TMO);
        break;
      end
    end
    @(posedge clk); #1;
    if (side) d_ren = 1'b0; else i_ren = 1'b0;
  endtask

  task automatic wait_mem_ren(input string name);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (!mem_ren && c < 20);
    check_int(name, mem_ren, 1);
  endtask

  task automatic wait_mem_idle();
    int c;
    c = 0;
    while (mem_busy && c < 20) begin @(posedge clk); #1; c++; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // fetch that gets flushed once its read is on the bus
  task automatic flush_fetch(input logic [AW-1:0] a, input int lat_set);
    int rv0;
    mem_lat = lat_set;
    rv0     = i_rv_cnt;
    i_ren   = 1'b1;
    i_raddr = a;
    wait_mem_ren("flush_grant");
    @(posedge clk); #1;
    i_flush = 1'b1;
    i_ren   = 1'b0;
    @(posedge clk); #1;
    i_flush = 1'b0;
    wait_mem_idle();
    check_int("flush_dropped", i_rv_cnt - rv0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, c0, rv0;
    // 1: reset with a fetch pending
    i_ren = 1'b1; i_raddr = 64'h40; mem_lat = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    c0 = cyc;
    req(1'b0, 64'h40, mem_fn(64'h40), lat);
    check_int("reset_ren_cycle", last_ren_cyc - c0, 1);
    check_int("reset_fetch_lat", lat, 2);

    // 2: single fetch, fixed memory data
    @(posedge clk); #1;
    fixed_en = 1'b1; fixed_val = 64'hDEAD; mem_lat = 1;
    c0 = cyc;
    rv0 = d_rv_cnt;
    req(1'b0, 64'h100, 64'hDEAD, lat);
    check_int("single_ren_cycle", last_ren_cyc - c0, 1);
    check_int("single_lat", lat, 3);
    check_int("single_no_d", d_rv_cnt - rv0, 0);
    fixed_en = 1'b0;

    // 3: contention, back-to-back on both sides
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          int l;
          req(1'b0, 64'h200 + 64'(k * 8), mem_fn(64'h200 + 64'(k * 8)), l);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          int l;
          req(1'b1, 64'h8000 + 64'(k * 8), mem_fn(64'h8000 + 64'(k * 8)), l);
        end
      end
    join

    // 4: flush in BUSY_I, flush with the response, flush in the grant cycle, then clean fetch
    @(posedge clk); #1;
    flush_fetch(64'h300, 2);
    flush_fetch(64'h340, 0);
    rv0 = i_rv_cnt; mem_lat = 1;
    i_ren = 1'b1; i_flush = 1'b1; i_raddr = 64'h380;
    @(posedge clk); #1;
    i_ren = 1'b0; i_flush = 1'b0;
    wait_mem_idle();
    check_int("flush_at_grant", i_rv_cnt - rv0, 0);
    req(1'b0, 64'h400, mem_fn(64'h400), lat);
    // flush while idle and while serving D has no effect
    i_flush = 1'b1;
    @(posedge clk); #1;
    req(1'b1, 64'h420, mem_fn(64'h420), lat);
    i_flush = 1'b0;
    req(1'b0, 64'h440, mem_fn(64'h440), lat);

    // 5: stray response in IDLE, then reset while BUSY_D
    rv0 = i_rv_cnt + d_rv_cnt;
    stray_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("stray_ignored", i_rv_cnt + d_rv_cnt - rv0, 0);
    mem_lat = 3;
    d_ren = 1'b1; d_raddr = 64'h900;
    wait_mem_ren("midrst_grant");
    @(posedge clk); #1;
    rst = 1'b1; d_ren = 1'b0;
    @(posedge clk); #1;
    check_int("midrst_state_idle", dbg_state, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_int("midrst_no_d", i_rv_cnt + d_rv_cnt - rv0, 0);
    req(1'b1, 64'h908, mem_fn(64'h908), lat);

    // random traffic on both sides with random memory latency
    mem_lat = -1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int l;
          logic [AW-1:0] a;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          a = {$urandom(), $urandom()};
          req(1'b0, a, mem_fn(a), l);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          int l;
          logic [AW-1:0] a;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          a = {$urandom(), $urandom()};
          req(1'b1, a, mem_fn(a), l);
        end
      end
    join

    repeat (5) @(posedge clk);
    check_int("i_queue_drained", i_exp_q.size(), 0);
    check_int("d_queue_drained", d_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "global timeout");
  end

endmodule
